nes_controller_emulator: RTL and testbench

Controller-side end of the NES serial pad protocol. Takes an 8-bit parallel button vector from the fabric, such as a PC/UART bridge or a scripted playback source. Answers a console or host reader's latch/pulse sequence by driving the serial data line bit by bit. It plugs into the same 3-wire interface the team's host-side pad reader drives, so the two blocks can be looped back on-chip or across a header.

---
 rtl/nes_pkg.sv | 23 ++
 rtl/nes_sync_edge.sv | 30 +++
 rtl/nes_controller_emulator.sv | 118 +++++++++++
 tb/tb_nes_controller_emulator.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared NES pad protocol constants and FSM encoding
`timescale 1ns/1ps
package nes_pkg;

  localparam int NES_BITS        = 8;
  localparam int DEFAULT_TIMEOUT = 50000;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOADING  = 2'd1,
    ST_SHIFTING = 2'd2
  } nes_state_e;

endpackage

// File: rtl/nes_sync_edge.sv
// rtl/nes_sync_edge.sv - 2-flop synchronizer with registered rise/fall detect
`timescale 1ns/1ps
module nes_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/nes_controller_emulator.sv
// rtl/nes_controller_emulator.sv - pad-side NES serial responder driven by a parallel button vector
`timescale 1ns/1ps
module nes_controller_emulator
  import nes_pkg::*;
#(
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter bit FILL_PRESSED = 1'b1,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                latch,
  input  logic                pulse,
  input  logic [NES_BITS-1:0] buttons,
  output logic                to_reader,
  output logic [3:0]          bit_index,
  output logic                busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic latch_s, latch_rise, latch_fall;
  logic pulse_s, pulse_rise, pulse_fall;
  logic sync_unused;

  nes_state_e          state_q, state_d;
  logic [NES_BITS-1:0] sr_q, sr_d;
  logic [3:0]          idx_q, idx_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic                to_reader_q;

  nes_sync_edge u_latch_sync (
    .clk_i   (clock),
    .rst_ni  (reset),
    .d_i     (latch),
    .level_o (latch_s),
    .rise_o  (latch_rise),
    .fall_o  (latch_fall)
  );

  nes_sync_edge u_pulse_sync (
    .clk_i   (clock),
    .rst_ni  (reset),
    .d_i     (pulse),
    .level_o (pulse_s),
    .rise_o  (pulse_rise),
    .fall_o  (pulse_fall)
  );

  assign sync_unused = latch_rise ^ latch_fall ^ pulse_s;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (latch_s) begin
          state_d = ST_LOADING;
          sr_d    = buttons;
          idx_d   = 4'd0;
        end
      end
      ST_LOADING: begin
        idx_d = 4'd0;
        // Keep following the live buttons until latch drops, then freeze the frame.
        if (latch_s) begin
          sr_d = buttons;
        end else begin
          state_d = ST_SHIFTING;
        end
      end
      ST_SHIFTING: begin
        if (latch_s) begin
          state_d = ST_LOADING;
          sr_d    = buttons;
          idx_d   = 4'd0;
        end else if (pulse_rise) begin
          sr_d  = {FILL_PRESSED, sr_q[NES_BITS-1:1]};
          idx_d = (idx_q == 4'(NES_BITS)) ? idx_q : idx_q + 4'd1;
        end else if (pulse_fall) begin
          cnt_d = '0;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          sr_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sr_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      idx_q       <= 4'd0;
      cnt_q       <= '0;
      to_reader_q <= ACTIVE_LOW;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      to_reader_q <= sr_q[0] ^ ACTIVE_LOW;
    end
  end

  assign to_reader = to_reader_q;
  assign bit_index = idx_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nes_controller_emulator.sv
// tb/tb_nes_controller_emulator.sv - self-checking bench for nes_controller_emulator
`timescale 1ns/1ps
module tb_nes_controller_emulator;

  localparam bit AL      = 1'b1;
  localparam bit FILL    = 1'b1;
  localparam int TIMEOUT = 300;

  logic       clock = 1'b0;
  logic       reset;
  logic       latch;
  logic       pulse;
  logic [7:0] buttons;
  logic       to_reader;
  logic [3:0] bit_index;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] b, b2, b3;
  int         n;

  nes_controller_emulator #(
    .ACTIVE_LOW   (AL),
    .FILL_PRESSED (FILL),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .latch     (latch),
    .pulse     (pulse),
    .buttons   (buttons),
    .to_reader (to_reader),
    .bit_index (bit_index),
    .busy      (busy)
  );

  always #10 clock = ~clock;

  // Line level of the k-th serial bit (k=0 right after latch) for a frame latched with value bv.
  function automatic logic exp_bit(input logic [7:0] bv, input int k);
    logic [2:0] i;
    logic       pressed;
    i       = k[2:0];
    pressed = (k < 8) ? bv[i] : FILL;
    return pressed ^ AL;
  endfunction

  function automatic logic [7:0] exp_idx(input int k);
    return (k > 8) ? 8'd8 : 8'(k);
  endfunction

  task automatic tick(input int c);
    repeat (c) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] bv);
    buttons = $urandom;
    latch   = 1'b1;
    tick(3);
    buttons = bv;
    tick(4);
    latch = 1'b0;
    tick(4);
    buttons = $urandom;
    chk("frame_bit0", {7'd0, to_reader}, {7'd0, exp_bit(bv, 0)});
    chk("frame_idx0", {4'd0, bit_index}, 8'd0);
    chk("frame_busy", {7'd0, busy}, 8'd1);
  endtask

  task automatic shift_pulses(input logic [7:0] bv, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      pulse = 1'b1;
      tick(3);
      chk("shift_idx", {4'd0, bit_index}, exp_idx(k));
      chk("shift_hold", {7'd0, to_reader}, {7'd0, exp_bit(bv, k - 1)});
      tick(1);
      chk("shift_bit", {7'd0, to_reader}, {7'd0, exp_bit(bv, k)});
      pulse   = 1'b0;
      buttons = $urandom;
      tick(4);
    end
  endtask

  initial begin
    reset   = 1'b0;
    latch   = 1'b0;
    pulse   = 1'b0;
    buttons = 8'hFF;

    for (int i = 0; i < 6; i++) begin
      latch = ~latch;
      tick(3);
      chk("rst_to_reader", {7'd0, to_reader}, {7'd0, AL});
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_idx", {4'd0, bit_index}, 8'd0);
    end
    latch = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(3);

    b       = 8'b1010_0101;
    buttons = b;
    latch   = 1'b1;
    tick(2);
    chk("lat_busy_2clk", {7'd0, busy}, 8'd0);
    tick(1);
    chk("lat_busy_3clk", {7'd0, busy}, 8'd1);
    chk("lat_line_3clk", {7'd0, to_reader}, {7'd0, AL});
    tick(1);
    chk("lat_line_4clk", {7'd0, to_reader}, 8'd0);
    tick(8);
    latch = 1'b0;
    tick(4);
    shift_pulses(b, 1, 8);
    shift_pulses(b, 9, 11);
    chk("extra_busy", {7'd0, busy}, 8'd1);
    chk("extra_line", {7'd0, to_reader}, 8'd0);

    repeat (6) begin
      b = $urandom;
      n = $urandom_range(0, 11);
      start_frame(b);
      shift_pulses(b, 1, n);
    end

    b = $urandom;
    start_frame(b);
    shift_pulses(b, 1, 2);
    tick(TIMEOUT - 20);
    chk("to_still_busy", {7'd0, busy}, 8'd1);
    tick(40);
    chk("to_idle", {7'd0, busy}, 8'd0);
    chk("to_line", {7'd0, to_reader}, {7'd0, AL});
    pulse = 1'b1;
    tick(4);
    pulse = 1'b0;
    tick(4);
    chk("idle_pulse_busy", {7'd0, busy}, 8'd0);
    chk("idle_pulse_line", {7'd0, to_reader}, {7'd0, AL});

    b2      = $urandom;
    buttons = b2;
    latch   = 1'b1;
    pulse   = 1'b1;
    tick(6);
    chk("lp_idle_bit0", {7'd0, to_reader}, {7'd0, exp_bit(b2, 0)});
    chk("lp_idle_idx", {4'd0, bit_index}, 8'd0);
    latch = 1'b0;
    tick(4);
    pulse = 1'b0;
    tick(4);
    chk("lp_idle_nofall", {7'd0, to_reader}, {7'd0, exp_bit(b2, 0)});
    shift_pulses(b2, 1, 3);

    b3      = $urandom;
    buttons = b3;
    latch   = 1'b1;
    pulse   = 1'b1;
    tick(6);
    chk("lp_shift_bit0", {7'd0, to_reader}, {7'd0, exp_bit(b3, 0)});
    chk("lp_shift_idx", {4'd0, bit_index}, 8'd0);
    latch = 1'b0;
    tick(4);
    pulse = 1'b0;
    tick(4);
    shift_pulses(b3, 1, 8);

    b = $urandom;
    start_frame(b);
    shift_pulses(b, 1, 3);
    #3 reset = 1'b0;
    #1;
    chk("midrst_line", {7'd0, to_reader}, {7'd0, AL});
    chk("midrst_idx", {4'd0, bit_index}, 8'd0);
    chk("midrst_busy", {7'd0, busy}, 8'd0);
    tick(2);
    reset = 1'b1;
    tick(4);
    chk("postrst_busy", {7'd0, busy}, 8'd0);
    b = $urandom;
    start_frame(b);
    shift_pulses(b, 1, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
